csa_dot_accumulator: RTL and testbench



---
 rtl/csa_dot_accumulator.sv | 102 ++++++++++
 tb/tb_csa_dot_accumulator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/csa_dot_accumulator.sv
// Resolves compressor sum/carry pairs with a registered CPA and accumulates them
// into a signed dot product, delivered on a valid/ready output with a saturating beat count.
module csa_dot_accumulator #(
  parameter int unsigned IN_SIZE  = 16,
  parameter int unsigned ACC_SIZE = 32,
  parameter int unsigned CNT_SIZE = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  sum_i,
  input  logic [IN_SIZE-1:0]  carry_i,
  input  logic                last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_SIZE-1:0] acc_o,
  output logic [CNT_SIZE-1:0] count_o,
  output logic                overflow_o
);

  logic                en;
  logic                fire;
  logic [IN_SIZE-1:0]  cpa;

  logic                v1_q;
  logic                last1_q;
  logic [ACC_SIZE-1:0] p_q;

  logic                first_q;
  logic [ACC_SIZE-1:0] acc_q;
  logic [CNT_SIZE-1:0] cnt_q;
  logic                ovf_q;

  logic [ACC_SIZE-1:0] base;
  logic [ACC_SIZE-1:0] nxt;
  logic [CNT_SIZE-1:0] cnt_base;
  logic [CNT_SIZE-1:0] cnt_nxt;
  logic                ovf_step;
  logic                ovf_nxt;

  // The whole pipeline freezes only while a finished result waits on the consumer.
  assign en         = !(out_valid_o && !out_ready_i);
  assign in_ready_o = en;
  assign fire       = in_valid_i && en;
  assign cpa        = sum_i + carry_i;

  always_comb begin
    base     = first_q ? '0 : acc_q;
    nxt      = base + p_q;
    ovf_step = (base[ACC_SIZE-1] == p_q[ACC_SIZE-1]) &&
               (nxt[ACC_SIZE-1] != base[ACC_SIZE-1]);
    cnt_base = first_q ? '0 : cnt_q;
    cnt_nxt  = (&cnt_base) ? cnt_base : cnt_base + CNT_SIZE'(1);
    ovf_nxt  = (!first_q && ovf_q) || ovf_step;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      p_q     <= '0;
    end else if (en) begin
      v1_q <= fire;
      if (fire) begin
        p_q     <= ACC_SIZE'($signed(cpa));
        last1_q <= last_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_q     <= 1'b1;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_o <= 1'b0;
      acc_o       <= '0;
      count_o     <= '0;
      overflow_o  <= 1'b0;
    end else if (en) begin
      if (v1_q && last1_q) begin
        acc_o       <= nxt;
        count_o     <= cnt_nxt;
        overflow_o  <= ovf_nxt;
        out_valid_o <= 1'b1;
        first_q     <= 1'b1;
      end else begin
        // en with out_valid_o set implies out_ready_i, so the held result is taken here.
        out_valid_o <= 1'b0;
        if (v1_q) begin
          acc_q   <= nxt;
          cnt_q   <= cnt_nxt;
          ovf_q   <= ovf_nxt;
          first_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_dot_accumulator.sv
// Directed bench for csa_dot_accumulator; a 16-bit-accumulator instance shares the stimulus
// so that signed overflow can be provoked with small operands.
module tb_csa_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic [15:0] carry;
  logic        last;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] acc;
  logic [7:0]  count;
  logic        overflow;

  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] acc16;
  logic [7:0]  count16;
  logic        overflow16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csa_dot_accumulator #(.IN_SIZE(16), .ACC_SIZE(32), .CNT_SIZE(8)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sum_i(sum), .carry_i(carry), .last_i(last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .acc_o(acc), .count_o(count), .overflow_o(overflow)
  );

  csa_dot_accumulator #(.IN_SIZE(16), .ACC_SIZE(16), .CNT_SIZE(8)) dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready16),
    .sum_i(sum), .carry_i(carry), .last_i(last), .out_valid_o(out_valid16),
    .out_ready_i(out_ready), .acc_o(acc16), .count_o(count16), .overflow_o(overflow16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s, input logic [15:0] c, input logic l);
    in_valid = 1'b1;
    sum      = s;
    carry    = c;
    last     = l;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum       = '0;
    carry     = '0;
    last      = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    step();
    rst = 1'b0;
    #1;
    check("rst_ready", in_ready, 1);

    // three-beat vector: 7 + 16 - 1
    send(16'h0003, 16'h0004, 1'b0);
    send(16'h0010, 16'h0000, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    in_valid = 1'b0;
    check("v1_latency_low", out_valid, 0);
    step();
    check("v1_valid", out_valid, 1);
    check("v1_acc", acc, 22);
    check("v1_count", count, 3);
    check("v1_ovf", overflow, 0);
    step();
    check("v1_taken", out_valid, 0);

    // CPA wrap cases
    send(16'h8000, 16'h8000, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b1);
    in_valid = 1'b0;
    check("wrap0_valid", out_valid, 1);
    check("wrap0_acc", acc, 0);
    check("wrap0_count", count, 1);
    step();
    check("wrapneg_valid", out_valid, 1);
    check("wrapneg_acc", acc, 32'hFFFF8000);
    check("wrapneg_acc16", acc16, 16'h8000);
    check("wrapneg_count", count, 1);
    step();
    check("wrap_taken", out_valid, 0);

    // backpressure: vector A = 5+6, vector B = 1+2+3 streams behind it
    out_ready = 1'b0;
    send(16'd5, 16'd0, 1'b0);
    send(16'd6, 16'd0, 1'b1);
    send(16'd1, 16'd0, 1'b0);
    sum  = 16'd2;
    last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_acc", acc, 11);
      check("stall_count", count, 2);
      step();
    end
    out_ready = 1'b1;
    step();
    check("release_taken", out_valid, 0);
    send(16'd3, 16'd0, 1'b1);
    in_valid = 1'b0;
    step();
    check("vB_valid", out_valid, 1);
    check("vB_acc", acc, 6);
    check("vB_count", count, 3);
    step();
    check("vB_taken", out_valid, 0);

    // back-to-back single-beat vectors
    send(16'd1, 16'd0, 1'b1);
    send(16'd2, 16'd0, 1'b1);
    check("b2b1_valid", out_valid, 1);
    check("b2b1_acc", acc, 1);
    send(16'd3, 16'd0, 1'b1);
    in_valid = 1'b0;
    check("b2b2_valid", out_valid, 1);
    check("b2b2_acc", acc, 2);
    step();
    check("b2b3_valid", out_valid, 1);
    check("b2b3_acc", acc, 3);
    check("b2b3_count", count, 1);
    step();
    check("b2b_taken", out_valid, 0);

    // signed overflow on the 16-bit accumulator, then cleared by the next vector
    send(16'h4000, 16'h0000, 1'b0);
    send(16'h4000, 16'h0000, 1'b1);
    in_valid = 1'b0;
    step();
    check("ovf_valid16", out_valid16, 1);
    check("ovf_acc16", acc16, 16'h8000);
    check("ovf_flag16", overflow16, 1);
    check("ovf_count16", count16, 2);
    check("ovf_acc32", acc, 32'h00008000);
    check("ovf_flag32", overflow, 0);
    send(16'd1, 16'd0, 1'b1);
    in_valid = 1'b0;
    step();
    check("ovfclr_acc16", acc16, 1);
    check("ovfclr_flag16", overflow16, 0);

    // reset mid-vector discards the partial sum
    send(16'd7, 16'd0, 1'b0);
    send(16'd9, 16'd0, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #3;
    check("midrst_valid", out_valid, 0);
    check("midrst_acc", acc, 0);
    check("midrst_count", count, 0);
    rst = 1'b0;
    step();
    check("midrst_noresult", out_valid, 0);
    send(16'd5, 16'd0, 1'b1);
    in_valid = 1'b0;
    check("post_rst_latency", out_valid, 0);
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_acc", acc, 5);
    check("post_rst_count", count, 1);
    step();
    check("post_rst_taken", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
